// File: rtl/axi_rd_responder.sv
// AXI4 read responder returning BURST_LEN address-patterned beats per AR transfer.
// Optional macro AXI_RD_RSP_THROTTLE_EN inserts LFSR-driven one-cycle RVALID gaps between beats.
module axi_rd_responder #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned RD_LATENCY = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'h2000_0000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [15:0]           bursts_done,
  output logic                  busy
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StGap} state_e;

  state_e                state_q, state_d;
  logic                  slot_full_q, slot_full_d;
  logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
  logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
  logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]            lat_cnt_q, lat_cnt_d;
  logic                  oor_q, oor_d;
  logic [15:0]           bursts_done_q, bursts_done_d;

  logic        ar_hs;
  logic        r_hs;
  logic        last_beat;
  logic [31:0] beat_word;

`ifdef AXI_RD_RSP_THROTTLE_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`endif

  assign ar_hs     = S_AXI_ARVALID & ~slot_full_q;
  assign r_hs      = (state_q == StBurst) & S_AXI_RREADY;
  assign last_beat = (beat_cnt_q == CntW'(BURST_LEN - 1));

  always_comb begin
    state_d       = state_q;
    slot_full_d   = slot_full_q;
    slot_addr_d   = slot_addr_q;
    beat_addr_d   = beat_addr_q;
    beat_cnt_d    = beat_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    oor_d         = oor_q;
    bursts_done_d = bursts_done_q;

    // Accept and consume are exclusive: accept needs an empty slot, consume a full one.
    if (ar_hs) begin
      slot_full_d = 1'b1;
      slot_addr_d = S_AXI_ARADDR;
    end

    unique case (state_q)
      StIdle: begin
        if (slot_full_q) begin
          state_d     = StWait;
          slot_full_d = 1'b0;
          beat_addr_d = slot_addr_q;
          oor_d       = (slot_addr_q >= ADDR_LIMIT);
          lat_cnt_d   = 8'(RD_LATENCY);
          beat_cnt_d  = '0;
        end
      end
      StWait: begin
        if (lat_cnt_q == 8'd0) begin
          state_d = StBurst;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      StBurst: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (last_beat) begin
            bursts_done_d = bursts_done_q + 16'd1;
            state_d       = StIdle;
          end else begin
            beat_addr_d = beat_addr_q + BeatBytes;
`ifdef AXI_RD_RSP_THROTTLE_EN
            if (lfsr_q[0]) begin
              state_d = StGap;
            end
`endif
          end
        end
      end
      StGap: begin
        state_d = StBurst;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q       <= StIdle;
      slot_full_q   <= 1'b0;
      slot_addr_q   <= '0;
      beat_addr_q   <= '0;
      beat_cnt_q    <= '0;
      lat_cnt_q     <= 8'd0;
      oor_q         <= 1'b0;
      bursts_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      slot_full_q   <= slot_full_d;
      slot_addr_q   <= slot_addr_d;
      beat_addr_q   <= beat_addr_d;
      beat_cnt_q    <= beat_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      oor_q         <= oor_d;
      bursts_done_q <= bursts_done_d;
    end
  end

  // R outputs decode registered state only, so they hold steady through a stall.
  assign beat_word     = 32'(beat_addr_q);
  assign S_AXI_ARREADY = ~slot_full_q;
  assign S_AXI_RVALID  = (state_q == StBurst);
  assign S_AXI_RLAST   = S_AXI_RVALID & last_beat;
  assign S_AXI_RRESP   = (S_AXI_RVALID & oor_q) ? 2'b10 : 2'b00;
  assign S_AXI_RDATA   = (S_AXI_RVALID & ~oor_q) ? {(DATA_WIDTH / 32){beat_word}} : '0;
  assign bursts_done   = bursts_done_q;
  assign busy          = (state_q != StIdle) | slot_full_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: table-driven bursts checked through a beat scoreboard,
// plus hand-written back-to-back, mid-burst reset and zero-latency wrap sequences.
module tb_axi_rd_responder;

  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 64;
  localparam int unsigned BL  = 16;
  localparam int unsigned LAT = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            mode;   // 0: RREADY always 1, 1: RREADY pattern 1,0,0,1
    logic [DW-1:0] beat0;
    logic [DW-1:0] beat15;
    logic [1:0]    resp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [15:0]   bursts_done;
  logic          busy;

  logic [AW-1:0] b_araddr;
  logic          b_arvalid, b_arready;
  logic [DW-1:0] b_rdata;
  logic [1:0]    b_rresp;
  logic          b_rlast, b_rvalid;
  logic          b_rready;
  logic [15:0]   b_bursts_done;
  logic          b_busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          mode = 0;
  beat_t       exp_q[$];
  int          beats_seen = 0;
  int          lasts_seen = 0;
  int          bidx = 0;
  int unsigned last_neg_cyc = 0;
  logic [DW-1:0] first_data, last_data;
  logic [1:0]    first_resp;

  axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .RD_LATENCY(LAT),
    .ADDR_LIMIT(30'h2000_0000)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .bursts_done(bursts_done), .busy(busy)
  );

  axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .RD_LATENCY(0),
    .ADDR_LIMIT(30'h2000_0000)
  ) dut_lat0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXI_ARADDR(b_araddr), .S_AXI_ARVALID(b_arvalid),
    .S_AXI_ARREADY(b_arready), .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp),
    .S_AXI_RLAST(b_rlast), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(b_rready),
    .bursts_done(b_bursts_done), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic beat_t model_beat(input logic [AW-1:0] a, input int k);
    beat_t         b;
    logic [AW-1:0] ak;
    logic [31:0]   w;
    ak     = a + AW'(k * (DW / 8));
    w      = 32'(ak);
    b.last = (k == BL - 1);
    if (a >= 30'h2000_0000) begin
      b.data = '0;
      b.resp = 2'b10;
    end else begin
      b.data = {w, w};
      b.resp = 2'b00;
    end
    return b;
  endfunction

  // RREADY driver
  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) rready = 1'b1;
      else rready = pat[3 - (ph % 4)];
      ph++;
    end
  end

  // Beat monitor and scoreboard; handshake seen at negedge completes on the next posedge.
  initial begin
    logic          stall_prev;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    beat_t         e;
    stall_prev = 1'b0;
    hold_data  = '0;
    hold_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 64'(rvalid), 64'd1);
          check("hold_data", 64'(rdata), 64'(hold_data));
          check("hold_last", 64'(rlast), 64'(hold_last));
        end
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat data %h, required no beat", rdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(rdata), 64'(e.data));
            check("beat_resp", 64'(rresp), 64'(e.resp));
            check("beat_last", 64'(rlast), 64'(e.last));
            if (bidx == 0) begin
              first_data = rdata;
              first_resp = rresp;
            end
            beats_seen++;
            bidx++;
            if (e.last) begin
              last_data    = rdata;
              last_neg_cyc = cyc;
              lasts_seen++;
              bidx = 0;
            end
          end
        end
        stall_prev = rvalid && !rready;
        hold_data  = rdata;
        hold_last  = rlast;
      end
    end
  end

  task automatic issue_ar(input logic [AW-1:0] a, input logic keep, output int unsigned e0);
    e0 = 0;
    @(posedge clk);
    #1;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk);
        #1;
        e0 = cyc;
        for (int k = 0; k < BL; k++) exp_q.push_back(model_beat(a, k));
        check("arready_fall", 64'(arready), 64'd0);
        if (!keep) arvalid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ar_timeout: got no ARREADY, required acceptance of %h", a);
    arvalid = 1'b0;
  endtask

  task automatic wait_first_valid(output int unsigned t);
    t = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (rvalid) begin
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rvalid_timeout: got RVALID=0, required RVALID=1");
  endtask

  task automatic wait_lasts(input int target);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (lasts_seen >= target) begin
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL burst_timeout: got %0d bursts, required %0d", lasts_seen, target);
  endtask

  initial begin
    vec_t        vecs[4];
    int unsigned e0, e0b, t, t2, e1;
    int          bd_exp;
    int          base;
    int          bad_resp, bad_data, bad_last, bad_valid;

    vecs[0] = '{addr: 30'h100, mode: 0, beat0: 64'h00000100_00000100,
                beat15: 64'h00000178_00000178, resp: 2'b00};
    vecs[1] = '{addr: 30'h1230, mode: 1, beat0: 64'h00001230_00001230,
                beat15: 64'h000012A8_000012A8, resp: 2'b00};
    vecs[2] = '{addr: 30'h2000_0000, mode: 0, beat0: 64'h0, beat15: 64'h0, resp: 2'b10};
    vecs[3] = '{addr: 30'h1FFF_FFFD, mode: 1, beat0: 64'h1FFFFFFD_1FFFFFFD,
                beat15: 64'h20000075_20000075, resp: 2'b00};

    rst = 1'b1;
    arvalid = 1'b0;
    araddr = '0;
    b_arvalid = 1'b0;
    b_araddr = '0;
    b_rready = 1'b1;
    bd_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_bursts_done", 64'(bursts_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      issue_ar(vecs[i].addr, 1'b0, e0);
      wait_first_valid(t);
      check("first_latency", 64'(t - e0), 64'(2 + LAT));
      check("busy_in_burst", 64'(busy), 64'd1);
      wait_lasts(lasts_seen + 1);
      bd_exp++;
      check("bursts_done", 64'(bursts_done), 64'(bd_exp));
      check("busy_after", 64'(busy), 64'd0);
      check("vec_beat0", 64'(first_data), 64'(vecs[i].beat0));
      check("vec_beat15", 64'(last_data), 64'(vecs[i].beat15));
      check("vec_resp", 64'(first_resp), 64'(vecs[i].resp));
      if (vecs[i].mode == 0) check("contiguous", 64'(last_neg_cyc - t), 64'(BL - 1));
    end
    mode = 0;

    // Back-to-back: ARVALID held across both addresses
    issue_ar(30'h0, 1'b1, e0);
    issue_ar(30'h80, 1'b0, e0b);
    check("b2b_accept_gap", 64'(e0b - e0), 64'd2);
    wait_first_valid(t);
    check("b2b_latency1", 64'(t - e0), 64'(2 + LAT));
    check("b2b_arready_low", 64'(arready), 64'd0);
    wait_lasts(lasts_seen + 1);
    e1 = last_neg_cyc + 1;
    wait_first_valid(t2);
    check("b2b_latency2", 64'(t2 - e1), 64'(2 + LAT));
    wait_lasts(lasts_seen + 1);
    bd_exp += 2;
    check("b2b_bursts_done", 64'(bursts_done), 64'(bd_exp));

    // Reset after beat 5 with an address pending
    issue_ar(30'h0, 1'b0, e0);
    issue_ar(30'h1000, 1'b0, e0b);
    base = beats_seen;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (beats_seen >= base + 6) break;
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_arready", 64'(arready), 64'd1);
    check("mid_rst_bursts_done", 64'(bursts_done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    exp_q.delete();
    bidx = 0;
    rst = 1'b0;
    bd_exp = 0;
    issue_ar(30'h40, 1'b0, e0);
    wait_first_valid(t);
    check("post_rst_latency", 64'(t - e0), 64'(2 + LAT));
    wait_lasts(lasts_seen + 1);
    bd_exp++;
    check("post_rst_beat0", 64'(first_data), 64'h00000040_00000040);
    check("post_rst_bursts_done", 64'(bursts_done), 64'(bd_exp));
    repeat (30) @(posedge clk);
    #1;
    check("no_stale_burst", 64'(bursts_done), 64'(bd_exp));
    check("idle_rvalid", 64'(rvalid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Zero-latency instance, start address wraps past the top of the address space
    @(posedge clk);
    #1;
    b_araddr = 30'h3FFF_FFF8;
    b_arvalid = 1'b1;
    e0 = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_arready) begin
        @(posedge clk);
        #1;
        e0 = cyc;
        break;
      end
    end
    b_arvalid = 1'b0;
    t = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (b_rvalid) begin
        t = cyc;
        break;
      end
    end
    check("lat0_latency", 64'(t - e0), 64'd2);
    check("lat0_beat0_resp", 64'(b_rresp), 64'd2);
    bad_resp = 0;
    bad_data = 0;
    bad_last = 0;
    bad_valid = 0;
    for (int k = 0; k < BL; k++) begin
      if (k == 1) check("lat0_beat1_resp", 64'(b_rresp), 64'd2);
      if (b_rresp != 2'b10) bad_resp++;
      if (b_rdata != '0) bad_data++;
      if (b_rlast != (k == BL - 1)) bad_last++;
      if (!b_rvalid) bad_valid++;
      @(posedge clk);
      #1;
    end
    check("lat0_resp_all", 64'(bad_resp), 64'd0);
    check("lat0_data_all", 64'(bad_data), 64'd0);
    check("lat0_last_pos", 64'(bad_last), 64'd0);
    check("lat0_valid_all", 64'(bad_valid), 64'd0);
    check("lat0_rvalid_end", 64'(b_rvalid), 64'd0);
    check("lat0_bursts_done", 64'(b_bursts_done), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
